// File: rtl/exc_mode_if.sv
// Bundles the exception-request inputs, control-byte write port and
// the SPSR / register-file / vector-fetch outputs of the mode sequencer.
interface exc_mode_if;
  logic        dabt;
  logic        fiq;
  logic        irq;
  logic        pabt;
  logic        und;
  logic        swi;
  logic [31:0] exc_pc;
  logic        cpsr_wr;
  logic [7:0]  cpsr_wdata;
  logic [4:0]  mode;
  logic        i_bit;
  logic        f_bit;
  logic        stall;
  logic        rf_we;
  logic [3:0]  rf_field;
  logic [31:0] rf_wdata;
  logic        spsr_we;
  logic [4:0]  spsr_mode;
  logic [7:0]  spsr_wdata;
  logic        vec_valid;
  logic [31:0] vec_addr;

  modport master (
    output dabt, fiq, irq, pabt, und, swi, exc_pc, cpsr_wr, cpsr_wdata,
    input  mode, i_bit, f_bit, stall, rf_we, rf_field, rf_wdata,
           spsr_we, spsr_mode, spsr_wdata, vec_valid, vec_addr
  );

  modport slave (
    input  dabt, fiq, irq, pabt, und, swi, exc_pc, cpsr_wr, cpsr_wdata,
    output mode, i_bit, f_bit, stall, rf_we, rf_field, rf_wdata,
           spsr_we, spsr_mode, spsr_wdata, vec_valid, vec_addr
  );
endinterface

// File: rtl/exc_mode_ctrl.sv
// Exception-entry and mode sequencer. Owns the control byte {I,F,M}
// and runs the three-cycle entry sequence: SPSR save, banked LR write,
// vector fetch. Also applies MSR / exception-return control writes.
//
// state | meaning
// IDLE  | no sequence running; arbitrate requests, accept cpsr_wr
// SAVE  | old control byte written to the new mode's SPSR
// LINK  | banked R14 written with the return address
// VECT  | one-cycle vector-fetch request
module exc_mode_ctrl #(
  parameter int HIGH_VEC = 0
) (
  input  logic      clk,
  input  logic      reset,
  exc_mode_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_SAVE, S_LINK, S_VECT} state_t;

  localparam logic [4:0] M_USR = 5'b10000;
  localparam logic [4:0] M_FIQ = 5'b10001;
  localparam logic [4:0] M_IRQ = 5'b10010;
  localparam logic [4:0] M_SVC = 5'b10011;
  localparam logic [4:0] M_ABT = 5'b10111;
  localparam logic [4:0] M_UND = 5'b11011;
  localparam logic [4:0] M_SYS = 5'b11111;
  localparam logic [31:0] VEC_BASE = (HIGH_VEC != 0) ? 32'hFFFF_0000 : 32'h0000_0000;

  state_t      state_q, state_d;
  logic [4:0]  mode_q, mode_d;
  logic        i_q, i_d, f_q, f_d;
  logic [4:0]  new_mode_q, new_mode_d;
  logic [4:0]  voff_q, voff_d;
  logic [31:0] lr_q, lr_d;
  logic [7:0]  old_q, old_d;
  logic        fiq_q, fiq_d;

  logic        stall_q, stall_d;
  logic        spsr_we_q, spsr_we_d;
  logic [4:0]  spsr_mode_q, spsr_mode_d;
  logic [7:0]  spsr_wdata_q, spsr_wdata_d;
  logic        rf_we_q, rf_we_d;
  logic [3:0]  rf_field_q, rf_field_d;
  logic [31:0] rf_wdata_q, rf_wdata_d;
  logic        vec_valid_q, vec_valid_d;
  logic [31:0] vec_addr_q, vec_addr_d;

  logic        take_fiq, take_irq, eligible;
  logic [4:0]  sel_mode, sel_off;

  // The T bit of an incoming write has no storage here.
  logic unused_t_bit;
  assign unused_t_bit = bus.cpsr_wdata[5];

  function automatic logic legal_mode(input logic [4:0] m);
    case (m)
      M_USR, M_FIQ, M_IRQ, M_SVC, M_ABT, M_UND, M_SYS: legal_mode = 1'b1;
      default:                                         legal_mode = 1'b0;
    endcase
  endfunction

  assign take_fiq = bus.fiq & ~f_q;
  assign take_irq = bus.irq & ~i_q;
  assign eligible = bus.dabt | take_fiq | take_irq | bus.pabt | bus.und | bus.swi;

  // Fixed-priority pick of the winning request: target mode and vector offset.
  always_comb begin
    sel_mode = M_SVC;
    sel_off  = 5'h08;
    if (bus.dabt) begin
      sel_mode = M_ABT; sel_off = 5'h10;
    end else if (take_fiq) begin
      sel_mode = M_FIQ; sel_off = 5'h1C;
    end else if (take_irq) begin
      sel_mode = M_IRQ; sel_off = 5'h18;
    end else if (bus.pabt) begin
      sel_mode = M_ABT; sel_off = 5'h0C;
    end else if (bus.und) begin
      sel_mode = M_UND; sel_off = 5'h04;
    end
  end

  // Next-state, control-byte update and output decode from the next state.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    i_d        = i_q;
    f_d        = f_q;
    new_mode_d = new_mode_q;
    voff_d     = voff_q;
    lr_d       = lr_q;
    old_d      = old_q;
    fiq_d      = fiq_q;
    case (state_q)
      S_IDLE: begin
        if (eligible) begin
          new_mode_d = sel_mode;
          voff_d     = sel_off;
          lr_d       = bus.exc_pc + (bus.dabt ? 32'd8 : 32'd4);
          old_d      = {i_q, f_q, 1'b0, mode_q};
          fiq_d      = ~bus.dabt & take_fiq;
          state_d    = S_SAVE;
        end else if (bus.cpsr_wr && (mode_q != M_USR)) begin
          i_d = bus.cpsr_wdata[7];
          f_d = bus.cpsr_wdata[6];
          if (legal_mode(bus.cpsr_wdata[4:0])) mode_d = bus.cpsr_wdata[4:0];
        end
      end
      S_SAVE: begin
        mode_d  = new_mode_q;
        i_d     = 1'b1;
        if (fiq_q) f_d = 1'b1;
        state_d = S_LINK;
      end
      S_LINK:  state_d = S_VECT;
      S_VECT:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    stall_d      = (state_d != S_IDLE);
    spsr_we_d    = (state_d == S_SAVE);
    spsr_mode_d  = spsr_we_d ? new_mode_d : 5'd0;
    spsr_wdata_d = spsr_we_d ? old_d : 8'd0;
    rf_we_d      = (state_d == S_LINK);
    rf_field_d   = rf_we_d ? 4'hE : 4'h0;
    rf_wdata_d   = rf_we_d ? lr_d : 32'd0;
    vec_valid_d  = (state_d == S_VECT);
    vec_addr_d   = vec_valid_d ? (VEC_BASE | {27'd0, voff_d}) : 32'd0;
  end

  // State, control byte, latched entry context and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      mode_q       <= M_SVC;
      i_q          <= 1'b1;
      f_q          <= 1'b1;
      new_mode_q   <= M_SVC;
      voff_q       <= 5'd0;
      lr_q         <= 32'd0;
      old_q        <= 8'd0;
      fiq_q        <= 1'b0;
      stall_q      <= 1'b0;
      spsr_we_q    <= 1'b0;
      spsr_mode_q  <= 5'd0;
      spsr_wdata_q <= 8'd0;
      rf_we_q      <= 1'b0;
      rf_field_q   <= 4'd0;
      rf_wdata_q   <= 32'd0;
      vec_valid_q  <= 1'b0;
      vec_addr_q   <= 32'd0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      i_q          <= i_d;
      f_q          <= f_d;
      new_mode_q   <= new_mode_d;
      voff_q       <= voff_d;
      lr_q         <= lr_d;
      old_q        <= old_d;
      fiq_q        <= fiq_d;
      stall_q      <= stall_d;
      spsr_we_q    <= spsr_we_d;
      spsr_mode_q  <= spsr_mode_d;
      spsr_wdata_q <= spsr_wdata_d;
      rf_we_q      <= rf_we_d;
      rf_field_q   <= rf_field_d;
      rf_wdata_q   <= rf_wdata_d;
      vec_valid_q  <= vec_valid_d;
      vec_addr_q   <= vec_addr_d;
    end
  end

  assign bus.mode       = mode_q;
  assign bus.i_bit      = i_q;
  assign bus.f_bit      = f_q;
  assign bus.stall      = stall_q;
  assign bus.rf_we      = rf_we_q;
  assign bus.rf_field   = rf_field_q;
  assign bus.rf_wdata   = rf_wdata_q;
  assign bus.spsr_we    = spsr_we_q;
  assign bus.spsr_mode  = spsr_mode_q;
  assign bus.spsr_wdata = spsr_wdata_q;
  assign bus.vec_valid  = vec_valid_q;
  assign bus.vec_addr   = vec_addr_q;

endmodule

// File: tb/tb_exc_mode_ctrl.sv
// Bench for exc_mode_ctrl: two instances (low and high vectors) share the
// same stimulus; a queue-based reference model predicts each strobe and
// the architectural control byte, and a negedge monitor compares.
module tb_exc_mode_ctrl;

  localparam logic [4:0] USR = 5'b10000, FIQ = 5'b10001, IRQ = 5'b10010,
                         SVC = 5'b10011, ABT = 5'b10111, UND = 5'b11011,
                         SYS = 5'b11111;
  // Request index order is priority order: dabt, fiq, irq, pabt, und, swi.
  localparam logic [4:0] EX_MODE [0:5] = '{ABT, FIQ, IRQ, ABT, UND, SVC};
  localparam logic [4:0] EX_OFF  [0:5] = '{5'h10, 5'h1C, 5'h18, 5'h0C, 5'h04, 5'h08};
  localparam logic [4:0] LEGAL   [0:6] = '{USR, FIQ, IRQ, SVC, ABT, UND, SYS};
  localparam logic [5:0] RD = 6'd1, RF = 6'd2, RI = 6'd4, RS = 6'd32, R0 = 6'd0;

  typedef struct packed { logic [4:0] m; logic [7:0] d; } spsr_rec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  exc_mode_if b0();
  exc_mode_if b1();

  exc_mode_ctrl #(.HIGH_VEC(0)) dut0 (.clk(clk), .reset(reset), .bus(b0.slave));
  exc_mode_ctrl #(.HIGH_VEC(1)) dut1 (.clk(clk), .reset(reset), .bus(b1.slave));

  int n_checks = 0;
  int n_errors = 0;
  int cur_dut  = 0;
  bit mon_en   = 1'b0;

  // Reference model state
  logic [4:0]  m_mode;
  logic        m_i, m_f, m_stall;
  int          m_busy = 0;
  logic [4:0]  p_mode, p_off;
  logic [31:0] p_lr;
  logic        p_fiq;

  spsr_rec_t   q_s[$];
  logic [31:0] q_r[$];
  logic [4:0]  q_v[$];

  function automatic bit is_legal(input logic [4:0] m);
    foreach (LEGAL[k]) if (LEGAL[k] == m) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s dut%0d t=%0t: got %h expected %h", nm, cur_dut, $time, act, exp);
    end
  endtask

  // Advance the model by one rising edge with the inputs that edge sampled.
  task automatic model_step(input logic rst, input logic [5:0] req,
                            input logic [31:0] pc, input logic wr, input logic [7:0] wd);
    int win;
    spsr_rec_t r;
    if (rst) begin
      m_mode = SVC; m_i = 1'b1; m_f = 1'b1; m_busy = 0; m_stall = 1'b0;
      return;
    end
    if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 2) begin
        m_mode = p_mode; m_i = 1'b1;
        if (p_fiq) m_f = 1'b1;
        q_r.push_back(p_lr);
      end else if (m_busy == 1) begin
        q_v.push_back(p_off);
      end
      m_stall = (m_busy != 0);
      return;
    end
    win = -1;
    for (int k = 0; k < 6; k++) begin
      if (win < 0 && req[k] && !(k == 1 && m_f) && !(k == 2 && m_i)) win = k;
    end
    if (win >= 0) begin
      r.m = EX_MODE[win];
      r.d = {m_i, m_f, 1'b0, m_mode};
      q_s.push_back(r);
      p_mode  = EX_MODE[win];
      p_off   = EX_OFF[win];
      p_lr    = pc + ((win == 0) ? 32'd8 : 32'd4);
      p_fiq   = (win == 1);
      m_busy  = 3;
      m_stall = 1'b1;
    end else begin
      m_stall = 1'b0;
      if (wr && m_mode != USR) begin
        m_i = wd[7];
        m_f = wd[6];
        if (is_legal(wd[4:0])) m_mode = wd[4:0];
      end
    end
  endtask

  task automatic step(input logic rst, input logic [5:0] req, input logic [31:0] pc,
                      input logic wr, input logic [7:0] wd);
    reset = rst;
    b0.dabt = req[0]; b0.fiq = req[1]; b0.irq = req[2];
    b0.pabt = req[3]; b0.und = req[4]; b0.swi = req[5];
    b0.exc_pc = pc; b0.cpsr_wr = wr; b0.cpsr_wdata = wd;
    b1.dabt = req[0]; b1.fiq = req[1]; b1.irq = req[2];
    b1.pabt = req[3]; b1.und = req[4]; b1.swi = req[5];
    b1.exc_pc = pc; b1.cpsr_wr = wr; b1.cpsr_wdata = wd;
    @(posedge clk);
    model_step(rst, req, pc, wr, wd);
    mon_en = 1'b1;
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, R0, 32'h0, 1'b0, 8'h00);
  endtask

  // Monitor: compare both instances against the model, pop a transaction
  // queue whenever the matching strobe is expected for this cycle.
  bit          hs, hr, hv;
  spsr_rec_t   fs;
  logic [31:0] fr;
  logic [4:0]  fv;

  task automatic check_bus(input int k, input logic st, input logic [4:0] md,
                           input logic ib, input logic fb, input logic swe,
                           input logic [4:0] smd, input logic [7:0] swd,
                           input logic rwe, input logic [3:0] rfl, input logic [31:0] rwd,
                           input logic vv, input logic [31:0] va);
    logic [31:0] base;
    cur_dut = k;
    base = (k == 1) ? 32'hFFFF_0000 : 32'h0;
    chk("stall", 32'(st), 32'(m_stall));
    chk("mode", 32'(md), 32'(m_mode));
    chk("i_bit", 32'(ib), 32'(m_i));
    chk("f_bit", 32'(fb), 32'(m_f));
    chk("spsr_we", 32'(swe), 32'(hs));
    if (swe && hs) begin
      chk("spsr_mode", 32'(smd), 32'(fs.m));
      chk("spsr_wdata", 32'(swd), 32'(fs.d));
    end
    chk("rf_we", 32'(rwe), 32'(hr));
    if (rwe && hr) begin
      chk("rf_field", 32'(rfl), 32'hE);
      chk("rf_wdata", rwd, fr);
    end
    chk("vec_valid", 32'(vv), 32'(hv));
    if (vv && hv) chk("vec_addr", va, base | {27'd0, fv});
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      hs = (q_s.size() != 0);
      hr = (q_r.size() != 0);
      hv = (q_v.size() != 0);
      if (hs) fs = q_s[0];
      if (hr) fr = q_r[0];
      if (hv) fv = q_v[0];
      check_bus(0, b0.stall, b0.mode, b0.i_bit, b0.f_bit, b0.spsr_we, b0.spsr_mode,
                b0.spsr_wdata, b0.rf_we, b0.rf_field, b0.rf_wdata, b0.vec_valid, b0.vec_addr);
      check_bus(1, b1.stall, b1.mode, b1.i_bit, b1.f_bit, b1.spsr_we, b1.spsr_mode,
                b1.spsr_wdata, b1.rf_we, b1.rf_field, b1.rf_wdata, b1.vec_valid, b1.vec_addr);
      if (hs) void'(q_s.pop_front());
      if (hr) void'(q_r.pop_front());
      if (hv) void'(q_v.pop_front());
    end
  end

  logic        lv_f = 1'b0, lv_i = 1'b0;
  logic [5:0]  rq;
  logic [31:0] pc;
  logic [7:0]  wd;
  int          sel;

  initial begin
    // Reset then idle
    step(1'b1, R0, 32'h0, 1'b0, 8'h00);
    step(1'b1, R0, 32'h0, 1'b0, 8'h00);
    idle(2);

    // SYS with I=F=0, then IRQ entry from 0x1000
    step(1'b0, R0, 32'h0, 1'b1, 8'h1F);
    step(1'b0, RI, 32'h0000_1000, 1'b0, 8'h00);
    idle(5);

    // dabt + fiq + irq together: ABT first, FIQ afterwards while fiq held
    step(1'b0, RD | RF | RI, 32'h0000_2000, 1'b0, 8'h00);
    for (int k = 0; k < 8; k++) step(1'b0, RF, 32'h0000_3000, 1'b0, 8'h00);
    idle(2);

    // Clear F then FIQ at the top of memory: LR wraps, high vector on dut1
    step(1'b0, R0, 32'h0, 1'b1, 8'h1F);
    step(1'b0, RF, 32'hFFFF_FFFC, 1'b0, 8'h00);
    idle(5);

    // cpsr_wr to USR, write ignored in USR, illegal M from SYS
    step(1'b1, R0, 32'h0, 1'b0, 8'h00);
    step(1'b0, R0, 32'h0, 1'b1, 8'h10);
    step(1'b0, R0, 32'h0, 1'b1, 8'h13);
    idle(1);
    step(1'b1, R0, 32'h0, 1'b0, 8'h00);
    step(1'b0, R0, 32'h0, 1'b1, 8'h1F);
    step(1'b0, R0, 32'h0, 1'b1, 8'h85);
    idle(1);

    // swi, then reset sampled during LINK
    step(1'b0, RS, 32'h0000_4000, 1'b0, 8'h00);
    idle(1);
    step(1'b1, R0, 32'h0, 1'b0, 8'h00);
    idle(4);

    // Randomised traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) == 0) lv_f = ~lv_f;
      if ($urandom_range(0, 7) == 0) lv_i = ~lv_i;
      rq = R0;
      rq[1] = lv_f;
      rq[2] = lv_i;
      if (m_busy == 0 && $urandom_range(0, 4) == 0) begin
        sel = $urandom_range(0, 3);
        rq[(sel == 0) ? 0 : sel + 2] = 1'b1;
        if ($urandom_range(0, 3) == 0) rq[$urandom_range(3, 5)] = 1'b1;
      end
      pc = $urandom;
      if ($urandom_range(0, 7) == 0) pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      wd = 8'($urandom);
      if ($urandom_range(0, 3) != 0) wd[4:0] = LEGAL[$urandom_range(0, 6)];
      step($urandom_range(0, 199) == 0, rq, pc, $urandom_range(0, 3) == 0, wd);
    end

    idle(6);
    cur_dut = 0;
    chk("queues_drained", 32'(q_s.size() + q_r.size() + q_v.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/exc_mode_ctrl.md
Name: exc_mode_ctrl

Overview:
- Exception-entry and mode sequencer. Owns the CPSR control byte (mode, I, F) that drives register-bank mapping.
- Prioritises pending exceptions and stalls the pipeline while the entry sequence runs.
- Entry sequence: save the old control byte to the new mode's SPSR, write the banked R14 with the return address, then issue the vector fetch.
- Sits beside decode and the register-file write port. Also applies MSR/return writes to the control byte.

Parameters:
- HIGH_VEC, 0, when 1 the vector base is 32'hFFFF0000, otherwise 32'h00000000.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- dabt  in  1  data abort pulse.
- fiq  in  1  FIQ level request.
- irq  in  1  IRQ level request.
- pabt  in  1  prefetch abort pulse.
- und  in  1  undefined-instruction pulse.
- swi  in  1  software interrupt pulse.
- exc_pc  in  32  address of the aborted or interrupted instruction.
- cpsr_wr  in  1  MSR or exception-return write strobe.
- cpsr_wdata  in  8  write data {I,F,T,M[4:0]}; T is ignored.
- mode  out  5  current mode; feeds the register mapper.
- i_bit  out  1  IRQ disable.
- f_bit  out  1  FIQ disable.
- stall  out  1  pipeline hold.
- rf_we  out  1  register-file write strobe.
- rf_field  out  4  unmapped register number.
- rf_wdata  out  32  register-file write data.
- spsr_we  out  1  SPSR write strobe.
- spsr_mode  out  5  selects which banked SPSR is written.
- spsr_wdata  out  8  saved {I,F,T=0,M}.
- vec_valid  out  1  one-cycle vector-fetch request.
- vec_addr  out  32  vector address.

Behaviour:
- Mode encodings:
  - USR 10000, FIQ 10001, IRQ 10010, SVC 10011, ABT 10111, UND 11011, SYS 11111.
- Reset (synchronous, highest priority):
  - mode=SVC, i_bit=1, f_bit=1, state=IDLE.
  - stall, rf_we, spsr_we, vec_valid all 0; all data outputs 0.
  - Reset mid-sequence abandons the sequence with no further writes. No vector is issued on reset.
- States: IDLE, SAVE, LINK, VECT. All outputs are registered and decoded from state.
- IDLE:
  - stall=0.
  - A request is eligible when it is a sync pulse, when fiq=1 and f_bit=0, or when irq=1 and i_bit=0. Masking uses the current registered i_bit/f_bit.
  - Priority: dabt > fiq > irq > pabt > und > swi.
  - On an eligible request at edge N: latch the winner, exc_pc and the old {I,F,M}, then go to SAVE.
- Exception table (new mode, vector offset, LR):
  - dabt: ABT, 0x10, exc_pc+8.
  - fiq: FIQ, 0x1C, exc_pc+4.
  - irq: IRQ, 0x18, exc_pc+4.
  - pabt: ABT, 0x0C, exc_pc+4.
  - und: UND, 0x04, exc_pc+4.
  - swi: SVC, 0x08, exc_pc+4.
  - LR addition is modulo 2^32.
- SAVE (cycle N+1):
  - stall=1, spsr_we=1, spsr_mode=new mode, spsr_wdata={oldI,oldF,0,oldM}.
  - At the end of the cycle: mode=new mode, i_bit=1, and f_bit=1 only for fiq (f_bit unchanged otherwise). Next state LINK.
- LINK (N+2):
  - stall=1, rf_we=1, rf_field=4'hE, rf_wdata=LR.
  - mode already holds the new mode, so the mapper selects the banked R14. Next state VECT.
- VECT (N+3):
  - stall=1, vec_valid=1, vec_addr=base|offset. Next state IDLE.
- Stall timing: stall is high on N+1..N+3 and low again at N+4. Strobes are low in every state where they are not listed above.
- Requests arriving outside IDLE are ignored. Pulses are lost; upstream guarantees none arrive while stalled. Level interrupts still held are re-evaluated in IDLE.
- cpsr_wr:
  - Honoured only in IDLE with no eligible exception in the same cycle. If an exception is also eligible, the exception wins and the write is dropped.
  - In USR mode the write is ignored entirely.
  - Otherwise I and F are updated. M is updated only if cpsr_wdata[4:0] is a legal encoding; an illegal M keeps the old mode.
  - The result is visible on the cycle after the write.

Test Plan:
- Reset then idle → mode=10011, i_bit=1, f_bit=1, stall=0, no strobes.
- From SYS with I=0, irq=1, exc_pc=0x1000 → spsr_we with spsr_mode=10010, spsr_wdata=0x1F (old I=0, F=0); then rf_we with rf_field=E, rf_wdata=0x1004 while mode=10010; then vec_valid with vec_addr=0x18; stall high for exactly 3 cycles; i_bit=1, f_bit unchanged.
- dabt, fiq and irq in the same cycle with F=0 → ABT entry, rf_wdata=exc_pc+8, vec 0x10. FIQ is taken only after return to IDLE, if fiq is still high.
- With HIGH_VEC=1, fiq with exc_pc=0xFFFFFFFC → LR=0x00000000 (wrap), vec_addr=0xFFFF001C, f_bit=1.
- cpsr_wr with 0x10 from SVC → mode=USR. A subsequent cpsr_wr with 0x13 → ignored. cpsr_wr with an illegal M=00101 from SYS → I/F updated, mode unchanged.
- swi accepted, reset asserted during LINK → no vec_valid, mode=SVC next cycle, stall=0.
